execute_eflags_reg: RTL
=======================

# execute_eflags_reg

Holds the speculative and committed EFLAGS state of the execute stage and resolves x86 condition codes for Jcc/SETcc/CMOVcc. It sits directly downstream of the execute flag-setting logic (cmp/test). It latches the flag word that logic produces and feeds it back as `eflags_as_src` so untouched bits are preserved. A registered condition-evaluation path hands taken/not-taken to branch resolution one cycle later. On pipeline flush, the speculative copy rolls back to the committed copy.

## Interface
- No parameters; widths come from `common_params.h` (`REG_W`, `EFLAGS_CF/PF/ZF/SF/OF`, plus `EFLAGS_DF` when configured).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `stall`  in  1  pipeline hold; freezes the speculative register and the condition result.
- `flush`  in  1  squash speculative state (mispredict/exception).
- `wr_en`  in  1  instruction in EX writes flags this cycle.
- `eflags_in`  in  `REG_W`  new flag word from the flag-setting logic.
- `commit_en`  in  1  retiring instruction wrote flags.
- `commit_eflags`  in  `REG_W`  flag word of the retiring instruction.
- `cond_valid`  in  1  instruction in EX needs a condition evaluated.
- `cond_code`  in  4  x86 condition nibble (tttn).
- `eflags_as_src`  out  `REG_W`  speculative EFLAGS, combinational from the register.
- `eflags_committed`  out  `REG_W`  committed EFLAGS.
- `taken_valid`  out  1  registered: condition result available.
- `taken`  out  1  registered condition result.

## Operation
- Two registers: `spec_q` (drives `eflags_as_src`) and `comm_q` (drives `eflags_committed`).
- Reset value of both registers: `REG_W'h2`. Bit 1 reads as 1 at all times and ignores writes. Reserved bits 3, 5 and 15 read as 0 at all times.
- Reset value of `taken_valid` and `taken`: 0.
- `comm_q` loads `commit_eflags` when `commit_en` is high. `commit_en` is independent of `stall` and `flush`.
- `spec_q` update, in priority order:
  - `flush`: load `commit_en ? commit_eflags : comm_q`. A same-cycle commit is therefore visible after the flush.
  - `stall`: hold.
  - `wr_en`: load `eflags_in`.
  - otherwise: hold.
- Condition evaluation uses the current `spec_q`, i.e. the value before this cycle's write. The pipeline is in-order single-issue, so the producing instruction wrote at the previous edge and no bypass is needed. cc mapping:
  - 0 OF; 1 !OF
  - 2 CF; 3 !CF
  - 4 ZF; 5 !ZF
  - 6 CF|ZF; 7 !(CF|ZF)
  - 8 SF; 9 !SF
  - A PF; B !PF
  - C SF^OF; D !(SF^OF)
  - E ZF|(SF^OF); F !(ZF|(SF^OF))
- Result register:
  - `flush`: `taken_valid` <= 0.
  - `stall`: hold both outputs.
  - otherwise: `taken_valid` <= `cond_valid`, `taken` <= evaluated bit, or 0 when `cond_valid` is low.
- `wr_en` and `cond_valid` in the same cycle (e.g. ADC-like micro-ops) evaluate against the old flags; the write lands at the edge.

## Timing
- `eflags_as_src` reflects `wr_en` data one cycle after the write: 1-cycle write-to-read latency, 0-cycle read.
- Condition result: `cond_valid` at cycle N gives `taken_valid` at N+1.
- `flush` at N: `spec_q` is restored and `taken_valid` is 0 at N+1.
- Reset assertion clears all outputs immediately, independent of `clk`, including mid-stall or mid-flush.
- The first edge after `rstn` deassertion is a normal operating cycle.

## Configuration
- `EFLAGS_DF_EN` defined:
  - Adds inputs `set_df` and `clr_df` (1 bit each).
  - When not stalled, flushed or written, `spec_q[EFLAGS_DF]` <= 1 on `set_df` and 0 on `clr_df`. If both are high, `clr_df` wins.
  - `wr_en` takes precedence over both.
  - DF is restored by `flush` like every other bit.
- `EFLAGS_DF_EN` undefined: no such ports, and the DF bit follows `eflags_in`/`commit_eflags` like any other bit.

## Test plan
- Reset: drop `rstn` mid-cycle -> `eflags_as_src` = `eflags_committed` = 0x2 and `taken_valid` = 0 immediately.
- Write then branch: `wr_en` with ZF set (0x42) at N, `cond_valid` cc=4 at N+1 -> `taken_valid`=1, `taken`=1 at N+2. cc=5 in the same setup -> `taken`=0.
- Signed compare: flags with SF=1, OF=0 -> cc=C taken=1, cc=D taken=0, cc=E taken=1. With ZF=1, SF=OF -> cc=F taken=0.
- Flush rollback: commit 0x03, then `wr_en` 0x8C3. Assert `flush` the next cycle -> `eflags_as_src` = 0x03. With `commit_en` 0x46 in the flush cycle -> `eflags_as_src` = 0x46.
- Stall: `stall`=1 with `wr_en` 0x41 and `cond_valid` -> `spec_q` and `taken` outputs unchanged for the whole stall. Write accepted on the first unstalled cycle.
- Bit-1 rule: write `eflags_in` = 0 -> readback 0x2. Write 0xFFFF -> readback 0x7FD7 (bits 3, 5, 15 cleared).

Source files
------------

// File: rtl/execute_eflags_reg.sv
// Speculative/committed EFLAGS for the execute stage plus a registered Jcc/SETcc/CMOVcc condition resolver.
// Optional DF set/clear side inputs are compiled in with EFLAGS_DF_EN.
`ifndef REG_W
`define REG_W 32
`endif
`ifndef EFLAGS_CF
`define EFLAGS_CF 0
`endif
`ifndef EFLAGS_PF
`define EFLAGS_PF 2
`endif
`ifndef EFLAGS_ZF
`define EFLAGS_ZF 6
`endif
`ifndef EFLAGS_SF
`define EFLAGS_SF 7
`endif
`ifndef EFLAGS_DF
`define EFLAGS_DF 10
`endif
`ifndef EFLAGS_OF
`define EFLAGS_OF 11
`endif

module execute_eflags_reg (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [`REG_W-1:0] eflags_in,
  input  logic              commit_en,
  input  logic [`REG_W-1:0] commit_eflags,
  input  logic              cond_valid,
  input  logic [3:0]        cond_code,
`ifdef EFLAGS_DF_EN
  input  logic              set_df,
  input  logic              clr_df,
`endif
  output logic [`REG_W-1:0] eflags_as_src,
  output logic [`REG_W-1:0] eflags_committed,
  output logic              taken_valid,
  output logic              taken
);

  localparam logic [`REG_W-1:0] RESET_VAL = `REG_W'h2;

  logic [`REG_W-1:0] spec_q;
  logic [`REG_W-1:0] comm_q;
  logic [`REG_W-1:0] spec_d;
  logic              cond_hit;
  logic              cond_res;

  // Bit 1 is hardwired to 1; bits 3, 5 and 15 are reserved-zero.
  function automatic logic [`REG_W-1:0] fix_rsvd(input logic [`REG_W-1:0] v);
    logic [`REG_W-1:0] r;
    r     = v;
    r[1]  = 1'b1;
    r[3]  = 1'b0;
    r[5]  = 1'b0;
    r[15] = 1'b0;
    return r;
  endfunction

  always_comb begin
    spec_d = spec_q;
    if (flush) begin
      spec_d = commit_en ? commit_eflags : comm_q;
    end else if (!stall) begin
      if (wr_en) begin
        spec_d = eflags_in;
      end
`ifdef EFLAGS_DF_EN
      else if (clr_df) begin
        spec_d[`EFLAGS_DF] = 1'b0;
      end else if (set_df) begin
        spec_d[`EFLAGS_DF] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spec_q <= RESET_VAL;
      comm_q <= RESET_VAL;
    end else begin
      spec_q <= fix_rsvd(spec_d);
      if (commit_en) begin
        comm_q <= fix_rsvd(commit_eflags);
      end
    end
  end

  // Pairs of condition codes share a predicate; the low bit inverts it.
  always_comb begin
    cond_hit = 1'b0;
    case (cond_code[3:1])
      3'd0: cond_hit = spec_q[`EFLAGS_OF];
      3'd1: cond_hit = spec_q[`EFLAGS_CF];
      3'd2: cond_hit = spec_q[`EFLAGS_ZF];
      3'd3: cond_hit = spec_q[`EFLAGS_CF] | spec_q[`EFLAGS_ZF];
      3'd4: cond_hit = spec_q[`EFLAGS_SF];
      3'd5: cond_hit = spec_q[`EFLAGS_PF];
      3'd6: cond_hit = spec_q[`EFLAGS_SF] ^ spec_q[`EFLAGS_OF];
      3'd7: cond_hit = spec_q[`EFLAGS_ZF] | (spec_q[`EFLAGS_SF] ^ spec_q[`EFLAGS_OF]);
      default: cond_hit = 1'b0;
    endcase
    cond_res = cond_valid & (cond_hit ^ cond_code[0]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taken_valid <= 1'b0;
      taken       <= 1'b0;
    end else if (flush) begin
      taken_valid <= 1'b0;
    end else if (!stall) begin
      taken_valid <= cond_valid;
      taken       <= cond_res;
    end
  end

  assign eflags_as_src    = spec_q;
  assign eflags_committed = comm_q;

endmodule
